// File: rtl/pipeline_remul_if.sv
// rtl/pipeline_remul_if.sv - operand/result bundle for the quotient*divisor+remainder pipeline
//
// Ports carried:
//   in_valid, stall               : issue qualifier and global freeze (master -> slave)
//   quotient, divisor, remainder  : operand triple (master -> slave)
//   dividend, full_result         : low DIVIDEND bits and full-width result (slave -> master)
//   out_valid, overflow           : result qualifier and "does not fit" flag (slave -> master)
interface pipeline_remul_if #(
    parameter int DIVIDEND = 3,
    parameter int DIVISOR  = 2
);
    logic                         in_valid;
    logic                         stall;
    logic [DIVIDEND-1:0]          quotient;
    logic [DIVISOR-1:0]           divisor;
    logic [DIVISOR-1:0]           remainder;
    logic [DIVIDEND-1:0]          dividend;
    logic [DIVIDEND+DIVISOR-1:0]  full_result;
    logic                         out_valid;
    logic                         overflow;

    modport master (
        output in_valid, stall, quotient, divisor, remainder,
        input  dividend, full_result, out_valid, overflow
    );

    modport slave (
        input  in_valid, stall, quotient, divisor, remainder,
        output dividend, full_result, out_valid, overflow
    );
endinterface

// File: rtl/pipeline_remul.sv
// rtl/pipeline_remul.sv - pipelined shift-and-add reconstruction of quotient*divisor+remainder
//
// Ports:
//   clock    : rising-edge clock for all state
//   reset_n  : asynchronous active-low reset, clears valids and all stage data
//   bus      : pipeline_remul_if.slave (operands in, result/valid/overflow out)
//
// One registered stage per quotient bit, MSB first. Stage 0 seeds the
// accumulator with the zero-extended remainder and folds in quotient bit
// DIVIDEND-1; stage k folds in bit DIVIDEND-1-k. The accumulator is the full
// DIVIDEND+DIVISOR width, so no partial sum is ever truncated.
module pipeline_remul #(
    parameter int DIVIDEND = 3,
    parameter int DIVISOR  = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    pipeline_remul_if.slave bus
);
    localparam int W = DIVIDEND + DIVISOR;

    for (genvar k = 0; k < DIVIDEND; k++) begin : g_stage
        logic [W-1:0]        acc_r;
        logic [DIVIDEND-1:0] quo_r;
        logic [DIVISOR-1:0]  dvs_r;
        logic                vld_r;

        logic [W-1:0]        base;
        logic [DIVIDEND-1:0] q_in;
        logic [DIVISOR-1:0]  d_in;
        logic                v_in;
        logic [W-1:0]        addend;

        if (k == 0) begin : g_first
            assign base = {{DIVIDEND{1'b0}}, bus.remainder};
            assign q_in = bus.quotient;
            assign d_in = bus.divisor;
            assign v_in = bus.in_valid;
        end else begin : g_next
            assign base = g_stage[k-1].acc_r;
            assign q_in = g_stage[k-1].quo_r;
            assign d_in = g_stage[k-1].dvs_r;
            assign v_in = g_stage[k-1].vld_r;
        end

        // Weighted divisor for the quotient bit owned by this stage. Data is
        // computed even for bubbles so the pipeline contents stay deterministic.
        assign addend = q_in[DIVIDEND-1-k]
                      ? ({{DIVIDEND{1'b0}}, d_in} << (DIVIDEND-1-k))
                      : '0;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                acc_r <= '0;
                quo_r <= '0;
                dvs_r <= '0;
                vld_r <= 1'b0;
            end else if (!bus.stall) begin
                acc_r <= base + addend;
                quo_r <= q_in;
                dvs_r <= d_in;
                vld_r <= v_in;
            end
        end
    end

    // Final-stage operand copies have no consumer; they are kept so every
    // stage carries the same record, which helps when probing the pipeline.
    logic unused_carry;
    assign unused_carry = ^{g_stage[DIVIDEND-1].quo_r, g_stage[DIVIDEND-1].dvs_r};

    assign bus.full_result = g_stage[DIVIDEND-1].acc_r;
    assign bus.dividend    = g_stage[DIVIDEND-1].acc_r[DIVIDEND-1:0];
    assign bus.out_valid   = g_stage[DIVIDEND-1].vld_r;
    assign bus.overflow    = g_stage[DIVIDEND-1].vld_r
                           & (|g_stage[DIVIDEND-1].acc_r[W-1:DIVIDEND]);
endmodule

// File: tb/tb_pipeline_remul.sv
// tb/tb_pipeline_remul.sv - randomized self-checking bench for pipeline_remul
module tb_pipeline_remul;
    localparam int DD = 3;
    localparam int DS = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    pipeline_remul_if #(.DIVIDEND(DD), .DIVISOR(DS)) bus ();

    pipeline_remul #(.DIVIDEND(DD), .DIVISOR(DS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    int seen;

    // Scoreboard: each issued operation with the number of accepted edges it
    // has experienced. An operation is presented at the output once it has
    // aged DD edges, and leaves on the next non-stalled edge.
    typedef struct {
        int unsigned val;
        int          age;
    } op_t;
    op_t sb[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic v, input logic st,
                              input int unsigned q, input int unsigned d, input int unsigned r);
        if (!reset_n || st) return;
        if (sb.size() > 0 && sb[0].age == DD) void'(sb.pop_front());
        foreach (sb[i]) sb[i].age++;
        if (v) sb.push_back('{q * d + r, 1});
    endtask

    task automatic check_outputs(input string tag);
        logic        exp_v;
        int unsigned v;
        exp_v = (sb.size() > 0) && (sb[0].age == DD);
        check_eq({tag, "_valid"}, bus.out_valid, exp_v);
        if (exp_v) begin
            v = sb[0].val;
            check_eq({tag, "_full"}, bus.full_result, v);
            check_eq({tag, "_div"},  bus.dividend,    v % (1 << DD));
            check_eq({tag, "_ovf"},  bus.overflow,    v >= (1 << DD));
        end else begin
            check_eq({tag, "_ovf_idle"}, bus.overflow, 1'b0);
        end
    endtask

    task automatic cycle(input logic v, input logic st,
                         input int unsigned q, input int unsigned d, input int unsigned r,
                         input string tag);
        bus.in_valid  = v;
        bus.stall     = st;
        bus.quotient  = q[DD-1:0];
        bus.divisor   = d[DS-1:0];
        bus.remainder = r[DS-1:0];
        model_edge(v, st, q % (1 << DD), d % (1 << DS), r % (1 << DS));
        @(posedge clock);
        #1;
        check_outputs(tag);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_valid"}, bus.out_valid,   1'b0);
        check_eq({tag, "_ovf"},   bus.overflow,    1'b0);
        check_eq({tag, "_full"},  bus.full_result, '0);
        check_eq({tag, "_div"},   bus.dividend,    '0);
    endtask

    initial begin
        int edges;
        bus.in_valid  = 1'b0;
        bus.stall     = 1'b0;
        bus.quotient  = '0;
        bus.divisor   = '0;
        bus.remainder = '0;

        #12;
        check_zero("reset");
        #5 reset_n = 1'b1;

        // q=3 d=2 r=1 -> 7 three edges later, then gone
        cycle(1'b1, 1'b0, 3, 2, 1, "basic");
        cycle(1'b0, 1'b0, 0, 0, 0, "basic");
        cycle(1'b0, 1'b0, 0, 0, 0, "basic");
        check_eq("basic_lat_valid", bus.out_valid,   1'b1);
        check_eq("basic_lat_full",  bus.full_result, 7);
        check_eq("basic_lat_div",   bus.dividend,    7);
        check_eq("basic_lat_ovf",   bus.overflow,    1'b0);
        cycle(1'b0, 1'b0, 0, 0, 0, "basic");
        check_eq("basic_after", bus.out_valid, 1'b0);

        // q=7 d=3 r=2 -> 23, overflows 3 bits
        cycle(1'b1, 1'b0, 7, 3, 2, "ovf");
        cycle(1'b0, 1'b0, 0, 0, 0, "ovf");
        cycle(1'b0, 1'b0, 0, 0, 0, "ovf");
        check_eq("ovf_full", bus.full_result, 23);
        check_eq("ovf_div",  bus.dividend,    7);
        check_eq("ovf_flag", bus.overflow,    1'b1);
        cycle(1'b0, 1'b0, 0, 0, 0, "ovf");

        // every {d,q,r} back to back, including divisor 0 and r>=d triples
        seen = 0;
        for (int i = 0; i < 128; i++) begin
            cycle(1'b1, 1'b0, (i >> 2) & 7, i >> 5, i & 3, "exh");
            if (bus.out_valid) seen++;
        end
        for (int i = 0; i < DD; i++) begin
            cycle(1'b0, 1'b0, 0, 0, 0, "exh");
            if (bus.out_valid) seen++;
        end
        check_eq("exh_count", seen, 128);

        // two stall cycles with garbage inputs extend latency by exactly 2
        cycle(1'b1, 1'b0, 5, 3, 1, "stl");
        cycle(1'b1, 1'b1, $urandom, $urandom, $urandom, "stl");
        cycle(1'b1, 1'b1, $urandom, $urandom, $urandom, "stl");
        edges = 3;
        while (!bus.out_valid && edges < 20) begin
            cycle(1'b0, 1'b0, 0, 0, 0, "stl");
            edges++;
        end
        check_eq("stall_latency", edges, DD + 2);
        check_eq("stall_full", bus.full_result, 16);
        cycle(1'b0, 1'b0, 0, 0, 0, "stl");

        // alternating bubbles reappear shifted by the pipeline depth
        for (int j = 0; j < 12; j++) begin
            cycle((j % 2) == 0, 1'b0, $urandom, $urandom, $urandom, "bub");
            if (j >= DD) check_eq("bubble_pat", bus.out_valid, (j % 2) == 0);
        end
        for (int j = 0; j < DD; j++) cycle(1'b0, 1'b0, 0, 0, 0, "bub");

        // random traffic with random stalls and bubbles
        for (int j = 0; j < 300; j++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                  $urandom, $urandom, $urandom, "rnd");
        for (int j = 0; j < DD + 1; j++) cycle(1'b0, 1'b0, 0, 0, 0, "rnd");

        // asynchronous reset mid-cycle with the pipeline full
        for (int j = 0; j < DD; j++) cycle(1'b1, 1'b0, $urandom, $urandom, $urandom, "pre");
        #3 reset_n = 1'b0;
        #1;
        check_zero("arst");
        sb.delete();
        @(posedge clock);
        #1;
        check_zero("arst_hold");
        #3 reset_n = 1'b1;
        seen = 0;
        for (int j = 0; j < DD + 3; j++) begin
            cycle(1'b0, 1'b0, 0, 0, 0, "post");
            if (bus.out_valid) seen++;
        end
        check_eq("rst_no_stale", seen, 0);
        cycle(1'b1, 1'b0, 6, 2, 3, "post");
        for (int j = 0; j < DD + 1; j++) cycle(1'b0, 1'b0, 0, 0, 0, "post");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1);
    end
endmodule
